// File: rtl/uart_receiver.sv
// UART 8N1 receive stage: oversampled deserialiser with valid/ready output, framing and overrun flags.
// Optional even-parity bit after the data bits when UART_RX_PARITY_EN is defined.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 rst_n,
  input  logic                 uart_rx_clk,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_HALF = CW'(OVERSAMPLE/2 - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  localparam int NUM_LANES = 2;
  // lane 0 is the rx pin (idles high), lane 1 the oversample clock
  localparam logic [NUM_LANES-1:0] SYNC_RST = 2'b01;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  logic [NUM_LANES-1:0][SYNC_STAGES-1:0] sync_ff;
  logic [NUM_LANES-1:0]                  lane_in;
  logic                                  rx_s, clk_s, clk_d, tick;

  state_t                state, state_nx;
  logic [CW-1:0]         cnt, cnt_nx;
  logic [BW-1:0]         bit_idx, bit_idx_nx;
  logic [DATA_BITS-1:0]  shreg, shreg_nx;
  logic                  par_bit, par_nx, par_err;
  logic                  stop_done, frame_ok, frame_bad, hs;

  assign lane_in = {uart_rx_clk, rx};

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < NUM_LANES; l++) sync_ff[l] <= {SYNC_STAGES{SYNC_RST[l]}};
      clk_d <= 1'b0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) sync_ff[l] <= {sync_ff[l][SYNC_STAGES-2:0], lane_in[l]};
      clk_d <= clk_s;
    end
  end

  assign rx_s  = sync_ff[0][SYNC_STAGES-1];
  assign clk_s = sync_ff[1][SYNC_STAGES-1];
  assign tick  = clk_s & ~clk_d;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_idx_nx;
      shreg   <= shreg_nx;
      par_bit <= par_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    bit_idx_nx = bit_idx;
    shreg_nx   = shreg;
    par_nx     = par_bit;
    stop_done  = 1'b0;
    if (tick) begin
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state_nx = S_START;
            cnt_nx   = '0;
          end
        end
        S_START: begin
          if (cnt == CNT_HALF) begin
            // a start bit that is high again at mid-bit is line noise
            state_nx   = rx_s ? S_IDLE : S_DATA;
            cnt_nx     = '0;
            bit_idx_nx = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_nx   = '0;
            shreg_nx = {rx_s, shreg[DATA_BITS-1:1]};
            if (bit_idx == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nx = S_PARITY;
`else
              state_nx = S_STOP;
`endif
            end else begin
              bit_idx_nx = bit_idx + 1'b1;
            end
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == CNT_LAST) begin
            par_nx   = rx_s;
            cnt_nx   = '0;
            state_nx = S_STOP;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            stop_done = 1'b1;
            state_nx  = S_IDLE;
            cnt_nx    = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
        default: begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  assign par_err = par_bit ^ (^shreg);
`else
  assign par_err = 1'b0;
`endif

  assign frame_ok  = stop_done & rx_s & ~par_err;
  assign frame_bad = stop_done & ~(rx_s & ~par_err);
  assign hs        = rx_valid & rx_ready;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_bad;
      // a new byte landing on the handshake cycle replaces the consumed one
      if (frame_ok && (!rx_valid || hs)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (hs) begin
        rx_valid <= 1'b0;
      end
      if (hs)                       overrun <= 1'b0;
      else if (frame_ok && rx_valid) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: directed scenarios plus random frames against a behavioural model.
`timescale 1ns/1ps
module tb_uart_receiver;
  localparam int DB  = 8;
  localparam int BIT = 8 * 10 * 16;  // uart_rx_clk = 8 sys_clk, 16 ticks per bit

  logic          sys_clk = 1'b0, rst_n = 1'b0, uart_rx_clk = 1'b0, rx = 1'b1, rx_ready = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, overrun;

  uart_receiver #(.DATA_BITS(DB), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .uart_rx_clk(uart_rx_clk), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_err(frame_err), .overrun(overrun));

  always #5  sys_clk     = ~sys_clk;
  always #40 uart_rx_clk = ~uart_rx_clk;

  int tests = 0, fails = 0;
  int vld_cyc = 0, ferr_cyc = 0, acc_cnt = 0;
  logic [DB-1:0] last_acc = '0;

  always @(posedge sys_clk) begin
    if (rx_valid) vld_cyc <= vld_cyc + 1;
    if (frame_err) ferr_cyc <= ferr_cyc + 1;
    if (rx_valid && rx_ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= rx_data;
    end
  end

  // reference model: what the consumer should see
  logic          m_valid = 1'b0, m_ovr = 1'b0;
  logic [DB-1:0] m_data = '0;
  int            m_ferr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [DB-1:0] b, input bit stop_bad, input bit par_flip, input int gap);
    rx = 1'b0; #BIT;
    for (int i = 0; i < DB; i++) begin rx = b[i]; #BIT; end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip; #BIT;
`endif
    if (stop_bad) begin
      rx = 1'b0; #(BIT*3/4);
      rx = 1'b1; #(BIT/4);
    end else begin
      rx = 1'b1; #BIT;
    end
    #gap;
  endtask

  task automatic model_frame(input logic [DB-1:0] b, input bit bad);
    if (bad)           m_ferr++;
    else if (!m_valid) begin m_valid = 1'b1; m_data = b; end
    else               m_ovr = 1'b1;
  endtask

  task automatic check_state(input string tag);
    @(negedge sys_clk);
    check({tag, ".valid"}, rx_valid, m_valid);
    check({tag, ".data"},  rx_data,  m_data);
    check({tag, ".ovr"},   overrun,  m_ovr);
    check({tag, ".ferr"},  ferr_cyc, m_ferr);
  endtask

  task automatic handshake(input string tag);
    int a0;
    a0 = acc_cnt;
    @(negedge sys_clk); rx_ready = 1'b1;
    @(negedge sys_clk); rx_ready = 1'b0;
    check({tag, ".acc"}, acc_cnt - a0, m_valid ? 1 : 0);
    if (m_valid) begin
      check({tag, ".accdata"}, last_acc, m_data);
      m_valid = 1'b0;
      m_ovr   = 1'b0;
    end
  endtask

  initial begin
    int a0, v0;
    logic [DB-1:0] b;
    bit bad, pf;

    #52;
    check("rst.data", rx_data, 0);
    check("rst.valid", rx_valid, 0);
    check("rst.ferr", frame_err, 0);
    check("rst.ovr", overrun, 0);
    rst_n = 1'b1;
    #(BIT);

    // immediate consumption
    @(negedge sys_clk); rx_ready = 1'b1;
    a0 = acc_cnt; v0 = vld_cyc;
    send(8'h55, 1'b0, 1'b0, 200);
    @(negedge sys_clk);
    check("t55.acc", acc_cnt - a0, 1);
    check("t55.data", last_acc, 8'h55);
    check("t55.vldcyc", vld_cyc - v0, 1);
    rx_ready = 1'b0;
    m_data = 8'h55;
    check_state("t55");

    // held until handshake
    send(8'hA3, 1'b0, 1'b0, 200);
    model_frame(8'hA3, 1'b0);
    check_state("tA3");
    repeat (100) @(negedge sys_clk);
    check_state("tA3hold");
    handshake("tA3hs");
    check_state("tA3post");

    // overrun
    send(8'h12, 1'b0, 1'b0, 0);
    model_frame(8'h12, 1'b0);
    send(8'h34, 1'b0, 1'b0, 200);
    model_frame(8'h34, 1'b0);
    check_state("ovr");
    handshake("ovrhs");
    check_state("ovrpost");

    // framing error, then recovery
    send(8'h7E, 1'b1, 1'b0, 400);
    model_frame(8'h7E, 1'b1);
    check_state("ferr");
    send(8'h81, 1'b0, 1'b0, 200);
    model_frame(8'h81, 1'b0);
    check_state("t81");
    handshake("t81hs");

    // short glitch on idle line
    @(negedge sys_clk); rx = 1'b0; #160; rx = 1'b1;
    #(BIT*2);
    check_state("glitch");

    // reset mid-byte with a byte pending and overrun set
    send(8'h11, 1'b0, 1'b0, 0);
    model_frame(8'h11, 1'b0);
    send(8'h22, 1'b0, 1'b0, 200);
    model_frame(8'h22, 1'b0);
    check_state("prerst");
    rx = 1'b0; #BIT;
    for (int i = 0; i < 4; i++) begin rx = i[0]; #BIT; end
    #(BIT/2);
    rst_n = 1'b0;
    #1;
    check("mrst.data", rx_data, 0);
    check("mrst.valid", rx_valid, 0);
    check("mrst.ferr", frame_err, 0);
    check("mrst.ovr", overrun, 0);
    rx = 1'b1; #200;
    rst_n = 1'b1;
    m_valid = 1'b0; m_ovr = 1'b0; m_data = '0;
    #BIT;
    send(8'hC5, 1'b0, 1'b0, 200);
    model_frame(8'hC5, 1'b0);
    check_state("tC5");
    handshake("tC5hs");

`ifdef UART_RX_PARITY_EN
    send(8'h07, 1'b0, 1'b0, 200);
    model_frame(8'h07, 1'b0);
    check_state("par_ok");
    handshake("par_okhs");
    send(8'h07, 1'b0, 1'b1, 200);
    model_frame(8'h07, 1'b1);
    check_state("par_bad");
`endif

    // random frames with random errors and consumer behaviour
    for (int n = 0; n < 16; n++) begin
      b   = DB'($urandom);
      bad = ($urandom_range(0, 4) == 0);
`ifdef UART_RX_PARITY_EN
      pf  = ($urandom_range(0, 5) == 0);
`else
      pf  = 1'b0;
`endif
      send(b, bad, pf, 300);
      model_frame(b, bad | pf);
      check_state("rnd");
      if ($urandom_range(0, 1) == 1) begin
        handshake("rndhs");
        check_state("rndpost");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial receive stage for the UART example. It sits directly downstream of the UART clock generator and consumes its `uart_rx_clk` 16x-oversampling clock as a sampled enable, not as a clock. It deserialises 8N1 frames from the `rx` pin and presents each byte on a valid/ready handshake. It also reports framing and overrun errors.

## Interface
- `DATA_BITS`, 8: payload bits per frame, LSB first.
- `OVERSAMPLE`, 16: `uart_rx_clk` rising edges per bit period.
- `SYNC_STAGES`, 2: flip-flop stages on `rx` and `uart_rx_clk` (minimum 2).

Ports:
- `sys_clk`  in  1  system clock; the only clock in the block.
- `rst_n`  in  1  asynchronous active-low reset.
- `uart_rx_clk`  in  1  oversample clock from the clock generator. It is synchronised into `sys_clk`; each rising edge produces a one-cycle `tick`.
- `rx`  in  1  serial line, idle high.
- `rx_data`  out  DATA_BITS  received byte; stable while `rx_valid`=1.
- `rx_valid`  out  1  byte available; held until accepted.
- `rx_ready`  in  1  consumer accepts the byte when `rx_valid && rx_ready` at a `sys_clk` edge.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  sticky: a good frame completed while `rx_valid`=1.

## Operation
- Both inputs pass through a `SYNC_STAGES` synchroniser.
- `tick` = synced `uart_rx_clk` high AND its previous value low.
- All FSM and counter activity advances only on `tick`.
- A 4-bit sample counter `cnt` counts ticks within a bit period and wraps at `OVERSAMPLE-1`.
- FSM states:
  - IDLE: on a tick with synced `rx`=0, go to START with `cnt`=0.
  - START: at `cnt`=OVERSAMPLE/2-1 (mid-bit), if `rx`=0 go to DATA with `cnt`=0 and bit index=0. If `rx`=1 it is a glitch: return to IDLE and report nothing.
  - DATA: at `cnt`=OVERSAMPLE-1, shift `rx` into the MSB of the shift register (this yields LSB-first order). After DATA_BITS samples, go to STOP (or PARITY when compiled in).
  - PARITY (only with the macro): at `cnt`=OVERSAMPLE-1, capture the parity bit, then go to STOP.
  - STOP: at `cnt`=OVERSAMPLE-1, sample `rx`, then always return to IDLE on the same tick, so the next start edge can be detected immediately.
- Stop sample = 1 with no error: the frame is good.
  - If `rx_valid`=0, or a handshake occurs in the same cycle: load `rx_data` and set `rx_valid`.
  - Otherwise: drop the new byte, keep the old `rx_data`, and set `overrun`.
- Stop sample = 0: pulse `frame_err` and discard the byte; `rx_valid` and `rx_data` are unchanged.
- Handshake: when `rx_valid && rx_ready`, clear `rx_valid` next cycle and clear `overrun`. A same-cycle new good frame wins: `rx_valid` stays 1 and `rx_data` takes the new byte.
- `rx_ready` has no effect while `rx_valid`=0.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overrun`=0, FSM=IDLE, `cnt`=0. Synchroniser flops reset to 1 for `rx` and 0 for `uart_rx_clk`.
- `tick` asserts SYNC_STAGES+1 `sys_clk` cycles after a `uart_rx_clk` rising edge.
- `rx_valid`, `rx_data`, `frame_err` and `overrun` update on the `sys_clk` edge following the tick that samples the stop bit.
- Frame detection latency from the falling start edge is one tick of uncertainty plus OVERSAMPLE/2 ticks to mid-start.
- Reset asserted mid-frame aborts immediately: all outputs return to reset values and no partial byte is ever presented.
- `uart_rx_clk` stuck at either level means no tick, so the FSM holds its state indefinitely.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - Adds the PARITY state and expects one even-parity bit after the data bits.
  - A parity mismatch is treated exactly like a framing error: `frame_err` pulses and the byte is discarded. The stop bit is still sampled to resynchronise.
- `UART_RX_PARITY_EN` undefined: no PARITY state and plain 8N1 frames.

## Test plan
- Reset, then drive `uart_rx_clk` with a period of 8 `sys_clk` and send 0x55 8N1 with `rx_ready`=1 → `rx_valid` pulses one cycle with `rx_data`=0x55; no `frame_err`, no `overrun`.
- Send 0xA3 with `rx_ready`=0, hold for 100 cycles, then raise `rx_ready` → `rx_valid` stays 1 with `rx_data`=0xA3 until the handshake, then 0.
- Send 0x12 then 0x34 back-to-back with `rx_ready`=0 → `rx_data`=0x12 and `overrun`=1. Handshake → `overrun`=0 and `rx_valid`=0.
- Send 0x7E with the stop bit forced low → one-cycle `frame_err`, `rx_valid` stays 0, and the next frame 0x81 is received correctly.
- A 2-tick low glitch on idle `rx` → FSM returns to IDLE and no outputs change. Assert `rst_n`=0 mid-byte → all outputs 0 at once, and a fresh frame 0xC5 is received correctly afterwards.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 1 → accepted; 0x07 with parity bit 0 → `frame_err`, byte discarded.
